// File: rtl/inst_encoder.sv
// Packs field-level instruction descriptors into 32-bit MIPS words, buffers them and streams them to instruction memory.
// Define INST_ENCODER_DELAY_SLOT_PAD_EN to write a NOP after every BEQ/J word.
module inst_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [1:0]        in_alu_fn,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [25:0]       in_imm,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

`ifdef INST_ENCODER_DELAY_SLOT_PAD_EN
  typedef enum logic [1:0] {IDLE, WRITE, PAD} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE} state_t;
`endif

  state_t            r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic [31:0]       w_word;
  logic [5:0]        w_funct;
  logic              w_legal;
  logic              w_push;
  logic              w_pop;
  logic              w_pad;

  always_comb begin
    w_legal = 1'b1;
    w_word  = '0;
    case (in_alu_fn)
      2'd0:    w_funct = 6'b100000;
      2'd1:    w_funct = 6'b100010;
      2'd2:    w_funct = 6'b100100;
      default: w_funct = 6'b100101;
    endcase
    case (in_kind)
      3'd0:    w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, w_funct};
      3'd1:    w_word = {6'b100011, in_rs, in_rt, in_imm[15:0]};
      3'd2:    w_word = {6'b101011, in_rs, in_rt, in_imm[15:0]};
      3'd3:    w_word = {6'b000100, in_rs, in_rt, in_imm[15:0]};
      3'd4:    w_word = {6'b001101, in_rs, in_rt, in_imm[15:0]};
      3'd5:    w_word = {6'b000010, in_imm};
      default: w_legal = 1'b0;
    endcase
  end

  assign in_ready = !rst && (r_count < FULL);
  assign w_push   = in_valid && in_ready && w_legal;

`ifdef INST_ENCODER_DELAY_SLOT_PAD_EN
  assign w_pad = (r_state == WRITE) &&
                 (r_wdata[31:26] == 6'b000100 || r_wdata[31:26] == 6'b000010);
`else
  assign w_pad = 1'b0;
`endif

  // A pad cycle takes the slot a pop would have used; load_base always blocks the pop.
  always_comb begin
    w_pop = 1'b0;
    if (r_state == IDLE)
      w_pop = (r_count != '0) && !load_base;
    else if (mem_ready)
      w_pop = (r_count != '0) && !load_base && !w_pad;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (in_valid && in_ready && !w_legal)
        r_err <= 1'b1;
    end
  end

  // WRITE and PAD share the completion logic; PAD holds a zero word so it never re-triggers padding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE) begin
      if (load_base)
        r_addr <= base_addr;
      if (w_pop) begin
        r_wdata <= r_mem[r_rd_ptr];
        r_state <= WRITE;
        r_we    <= 1'b1;
      end
    end else if (mem_ready) begin
      r_addr <= load_base ? base_addr : r_addr + 1'b1;
`ifdef INST_ENCODER_DELAY_SLOT_PAD_EN
      if (w_pad) begin
        r_wdata <= '0;
        r_state <= PAD;
      end else
`endif
      if (w_pop) begin
        r_wdata <= r_mem[r_rd_ptr];
        r_state <= WRITE;
      end else begin
        r_state <= IDLE;
        r_we    <= 1'b0;
      end
    end else if (load_base) begin
      r_addr <= base_addr;
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign err       = r_err;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_kind = '0;
  logic [1:0]  in_alu_fn = '0;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic [25:0] in_imm = '0;
  logic        load_base = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        mem_we;
  logic        mem_ready = 1'b0;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        err;

`ifdef INST_ENCODER_DELAY_SLOT_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int w0;
  int idx;
  bit acc;

  logic [31:0] q[$];
  logic [7:0]  m_addr = '0;
  logic        m_err = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  prev_addr;
  logic [31:0] prev_data;
  logic [7:0]  last_addr = '0;
  logic [31:0] last_wdata = '0;
  logic [31:0] exp_w;

  inst_encoder #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_alu_fn(in_alu_fn), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_imm(in_imm), .load_base(load_base), .base_addr(base_addr),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoding built from field weights rather than bit concatenation.
  function automatic logic [31:0] encode(longint kind, longint fn, longint rs, longint rt,
                                         longint rd, longint imm);
    longint ops[6]    = '{0, 35, 43, 4, 13, 2};
    longint functs[4] = '{32, 34, 36, 37};
    longint v;
    if (kind == 0)
      v = rs * (2**21) + rt * (2**16) + rd * (2**11) + functs[fn];
    else if (kind == 5)
      v = ops[kind] * (2**26) + imm;
    else
      v = ops[kind] * (2**26) + rs * (2**21) + rt * (2**16) + (imm % 65536);
    return v[31:0];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_addr = '0;
      m_err  = 1'b0;
      hold   = 1'b0;
    end else begin
      check_eq("err", {31'b0, err}, {31'b0, m_err});
      if (hold) begin
        check_eq("hold_addr", {24'b0, mem_addr}, {24'b0, prev_addr});
        check_eq("hold_data", mem_wdata, prev_data);
      end
      if (in_valid && in_ready) begin
        if (in_kind < 3'd6) begin
          q.push_back(encode(in_kind, in_alu_fn, in_rs, in_rt, in_rd, in_imm));
          if (PAD_EN && (in_kind == 3'd3 || in_kind == 3'd5))
            q.push_back(32'h0);
        end else begin
          m_err = 1'b1;
        end
      end
      if (mem_we && mem_ready) begin
        n_writes++;
        check_eq("write_pending", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp_w = q.pop_front();
          check_eq("wdata", mem_wdata, exp_w);
          check_eq("waddr", {24'b0, mem_addr}, {24'b0, m_addr});
        end
        last_addr  = mem_addr;
        last_wdata = mem_wdata;
        m_addr     = m_addr + 8'd1;
      end
      if (load_base)
        m_addr = base_addr;
      hold      = mem_we && !mem_ready && !load_base;
      prev_addr = mem_addr;
      prev_data = mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int kind, input int fn, input int rs, input int rt,
                       input int rd, input int imm);
    in_kind   = 3'(kind);
    in_alu_fn = 2'(fn);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_imm    = 26'(imm);
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    in_valid  = 1'b0;
    load_base = 1'b0;
    mem_ready = 1'b0;
    base_addr = '0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check_eq("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check_eq("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_err", {31'b0, err}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Single ADD: latency and encoding
    drive(0, 0, 1, 2, 3, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("add_lat_early", {31'b0, mem_we}, 32'd0);
    tick();
    check_eq("add_we", {31'b0, mem_we}, 32'd1);
    check_eq("add_addr", {24'b0, mem_addr}, 32'h00);
    check_eq("add_data", mem_wdata, 32'h00221820);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check_eq("add_done", {31'b0, mem_we}, 32'd0);

    // LW then ORI, back-to-back writes
    reset_dut();
    mem_ready = 1'b1;
    drive(1, 0, 8, 9, 0, 'h0004);
    in_valid = 1'b1;
    tick();
    drive(4, 0, 0, 5, 0, 'h00FF);
    tick();
    in_valid = 1'b0;
    check_eq("lw_data", mem_wdata, 32'h8D090004);
    check_eq("lw_addr", {24'b0, mem_addr}, 32'h00);
    tick();
    check_eq("ori_data", mem_wdata, 32'h340500FF);
    check_eq("ori_addr", {24'b0, mem_addr}, 32'h01);
    tick();
    check_eq("lw_ori_idle", {31'b0, mem_we}, 32'd0);

    // Capacity: DEPTH in FIFO plus one in the output register
    reset_dut();
    w0 = n_writes;
    idx = 0;
    drive(0, 0, 0, 1, 2, 0);
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      acc = in_ready;
      tick();
      if (acc) begin
        idx++;
        drive(0, idx % 4, idx, idx + 1, idx + 2, 0);
      end
    end
    check_eq("cap_accepted", 32'(idx), 32'd5);
    check_eq("cap_full", {31'b0, in_ready}, 32'd0);
    mem_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check_eq("cap_sixth", 32'(idx), 32'd6);
    repeat (10) tick();
    check_eq("cap_writes", 32'(n_writes - w0), 32'd6);
    check_eq("cap_drained", 32'(q.size()), 32'd0);
    check_eq("cap_last_addr", {24'b0, last_addr}, 32'h05);

    // Illegal kind: sticky err, nothing written
    reset_dut();
    w0 = n_writes;
    drive(7, 0, 1, 1, 1, 0);
    in_valid = 1'b1;
    tick();
    check_eq("illegal_err", {31'b0, err}, 32'd1);
    drive(2, 0, 2, 3, 0, 'h0010);
    tick();
    in_valid = 1'b0;
    mem_ready = 1'b1;
    repeat (6) tick();
    check_eq("illegal_writes", 32'(n_writes - w0), 32'd1);
    check_eq("sw_data", last_wdata, 32'hAC430010);
    check_eq("sw_addr", {24'b0, last_addr}, 32'h00);
    check_eq("err_sticky", {31'b0, err}, 32'd1);

    // load_base to 0xFF, wrap, then reset during the second write
    reset_dut();
    w0 = n_writes;
    load_base = 1'b1;
    base_addr = 8'hFF;
    tick();
    load_base = 1'b0;
    drive(0, 0, 1, 2, 3, 0);
    in_valid = 1'b1;
    tick();
    drive(0, 1, 4, 5, 6, 0);
    tick();
    in_valid = 1'b0;
    check_eq("base_addr_ff", {24'b0, mem_addr}, 32'hFF);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check_eq("wrap_we", {31'b0, mem_we}, 32'd1);
    check_eq("wrap_addr", {24'b0, mem_addr}, 32'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_we", {31'b0, mem_we}, 32'd0);
    mem_ready = 1'b1;
    repeat (5) tick();
    check_eq("midrst_writes", 32'(n_writes - w0), 32'd1);
    check_eq("midrst_idle", {31'b0, mem_we}, 32'd0);

    // load_base while a write is stalled retargets the pending word
    reset_dut();
    drive(0, 2, 7, 8, 9, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    load_base = 1'b1;
    base_addr = 8'h40;
    tick();
    load_base = 1'b0;
    check_eq("retarget_addr", {24'b0, mem_addr}, 32'h40);
    mem_ready = 1'b1;
    repeat (3) tick();
    check_eq("retarget_written", {24'b0, last_addr}, 32'h40);

    // J word, with a trailing NOP only when padding is built in
    reset_dut();
    w0 = n_writes;
    load_base = 1'b1;
    base_addr = 8'h10;
    tick();
    load_base = 1'b0;
    drive(5, 0, 0, 0, 0, 'h0000010);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    mem_ready = 1'b1;
    repeat (6) tick();
    if (PAD_EN) begin
      check_eq("j_writes", 32'(n_writes - w0), 32'd2);
      check_eq("j_pad_data", last_wdata, 32'h00000000);
      check_eq("j_pad_addr", {24'b0, last_addr}, 32'h11);
    end else begin
      check_eq("j_writes", 32'(n_writes - w0), 32'd1);
      check_eq("j_data", last_wdata, 32'h08000010);
      check_eq("j_addr", {24'b0, last_addr}, 32'h10);
    end

    // Randomized traffic, checked by the scoreboard
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom % 2) == 0;
      drive(($urandom % 16) < 14 ? int'($urandom % 6) : int'(6 + $urandom % 2),
            int'($urandom % 4), int'($urandom % 32), int'($urandom % 32),
            int'($urandom % 32), int'($urandom % (1 << 26)));
      mem_ready = ($urandom % 4) != 0;
      load_base = ($urandom % 32) == 0;
      base_addr = 8'($urandom % 256);
      tick();
    end
    in_valid  = 1'b0;
    load_base = 1'b0;
    mem_ready = 1'b1;
    repeat (20) tick();
    check_eq("rand_drained", 32'(q.size()), 32'd0);
    check_eq("rand_idle", {31'b0, mem_we}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
